// File: rtl/avm_mac_driver.sv
// Purpose: Avalon-MM master that writes an incrementing operand block, then reads back one result word.
// Latency: bus request one cycle after start; done pulses two cycles after the read is accepted.
// Backpressure: avm_waitrequest stalls any request; address, data and strobes hold until acceptance.
//
// Ports:
//   clk, reset                        - rising-edge clock, synchronous active-high reset
//   start, cmd_base, cmd_len, cmd_data - command strobe and operands, sampled only in IDLE
//   busy, done, result                 - status, one-cycle completion pulse, last read data
//   avm_*                              - Avalon-MM master (chipselect/address/read/write/writedata
//                                        out; readdata/waitrequest in)
module avm_mac_driver #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [8:0]        cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              avm_chipselect,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_RDWAIT,
        S_DONE
    } state_t;

    state_t            state_q,  state_d;
    logic [ADDR_W-1:0] base_q,   base_d;
    logic [8:0]        len_q,    len_d;
    logic [DATA_W-1:0] data_q,   data_d;
    logic [8:0]        cnt_q,    cnt_d;
    logic              busy_q,   busy_d;
    logic              done_q,   done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              cs_q,     cs_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic              rd_q,     rd_d;
    logic              wr_q,     wr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    // Count of accepted writes including the one being accepted this cycle.
    logic [8:0]        cnt_nxt;

    // Every output comes straight from a flop. The next-state logic looks at
    // avm_waitrequest, so the request for the next word is precomputed here
    // and appears on the bus the cycle after acceptance without a bubble.
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cs_d     = cs_q;
        addr_d   = addr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        wdata_d  = wdata_q;
        cnt_nxt  = cnt_q + 9'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d = cmd_base;
                    len_d  = cmd_len;
                    data_d = cmd_data;
                    cnt_d  = 9'd0;
                    busy_d = 1'b1;
                    cs_d   = 1'b1;
                    addr_d = cmd_base;
                    if (cmd_len != 9'd0) begin
                        state_d = S_WRITE;
                        wr_d    = 1'b1;
                        wdata_d = cmd_data;
                    end else begin
                        // Empty operand block: go straight to the result read at base+0.
                        state_d = S_READ;
                        rd_d    = 1'b1;
                    end
                end
            end

            S_WRITE: begin
                if (!avm_waitrequest) begin
                    cnt_d = cnt_nxt;
                    if (cnt_nxt == len_q) begin
                        state_d = S_READ;
                        wr_d    = 1'b0;
                        rd_d    = 1'b1;
                        addr_d  = base_q + ADDR_W'(len_q);
                    end else begin
                        addr_d  = base_q + ADDR_W'(cnt_nxt);
                        wdata_d = data_q + DATA_W'(cnt_nxt);
                    end
                end
            end

            S_READ: begin
                if (!avm_waitrequest) begin
                    state_d = S_RDWAIT;
                    rd_d    = 1'b0;
                    cs_d    = 1'b0;
                end
            end

            S_RDWAIT: begin
                // Slave returns data exactly one cycle after acceptance.
                result_d = avm_readdata;
                state_d  = S_DONE;
                busy_d   = 1'b0;
                done_d   = 1'b1;
            end

            S_DONE: begin
                // start is deliberately not looked at here.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cs_d    = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cs_q     <= 1'b0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            len_q    <= len_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cs_q     <= cs_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign result         = result_q;
    assign avm_chipselect = cs_q;
    assign avm_address    = addr_q;
    assign avm_read       = rd_q;
    assign avm_write      = wr_q;
    assign avm_writedata  = wdata_q;

endmodule

// File: tb/tb_avm_mac_driver.sv
// Bench for avm_mac_driver: table vectors, directed corner sequences and
// randomized transactions checked against a transaction-level model.
module tb_avm_mac_driver;

    localparam int ADDR_W = 17;
    localparam int DATA_W = 32;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] cmd_base;
    logic [8:0]        cmd_len;
    logic [DATA_W-1:0] cmd_data;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              avm_chipselect;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    avm_mac_driver #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cmd_base        (cmd_base),
        .cmd_len         (cmd_len),
        .cmd_data        (cmd_data),
        .busy            (busy),
        .done            (done),
        .result          (result),
        .avm_chipselect  (avm_chipselect),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Bus observations
    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];
    logic [ADDR_W-1:0] ra_q[$];
    int done_cnt, busy_cycles, stall_cycles, wr_cycles, inv_err;
    int wprob;
    int stall_idx, stall_left;
    bit rd_pending;
    logic [DATA_W-1:0] rd_val;
    bit prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [DATA_W-1:0] prev_wdata;
    logic prev_rd, prev_wr;

    task automatic clear_mon();
        wa_q.delete();
        wd_q.delete();
        ra_q.delete();
        done_cnt     = 0;
        busy_cycles  = 0;
        stall_cycles = 0;
        wr_cycles    = 0;
        inv_err      = 0;
    endtask

    // One clock: at the falling edge act as the slave for the current cycle
    // (choose waitrequest, present read data one cycle after acceptance),
    // then record what the master did.
    task automatic tick();
        @(negedge clk);
        if (avm_write && stall_left > 0 && wa_q.size() == stall_idx) begin
            avm_waitrequest = 1'b1;
            stall_left--;
        end else begin
            avm_waitrequest = ($urandom_range(99) < wprob);
        end
        if (rd_pending) begin
            avm_readdata = rd_val;
            rd_pending   = 1'b0;
        end else begin
            avm_readdata = $urandom;
        end

        if (avm_read && avm_write) inv_err++;
        if (avm_chipselect !== (avm_read | avm_write)) inv_err++;
        if ((avm_read || avm_write) && !busy) inv_err++;
        if (done && busy) inv_err++;
        if (prev_stall && (avm_address !== prev_addr || avm_read !== prev_rd ||
                           avm_write !== prev_wr || (prev_wr && avm_writedata !== prev_wdata)))
            inv_err++;

        if (busy) busy_cycles++;
        if (done) done_cnt++;
        if (avm_write) wr_cycles++;
        if ((avm_read || avm_write) && avm_waitrequest) stall_cycles++;
        if (avm_write && !avm_waitrequest) begin
            wa_q.push_back(avm_address);
            wd_q.push_back(avm_writedata);
        end
        if (avm_read && !avm_waitrequest) begin
            ra_q.push_back(avm_address);
            rd_pending = 1'b1;
        end

        prev_stall = (avm_read || avm_write) && avm_waitrequest;
        prev_addr  = avm_address;
        prev_wdata = avm_writedata;
        prev_rd    = avm_read;
        prev_wr    = avm_write;
    endtask

    // Issue one command and compare the whole observed transaction with the
    // model: writes base+k / data+k for k<len, one read at base+len, result
    // equals the slave's read value, one done pulse, busy for len+2 cycles
    // plus every stalled request cycle.
    task automatic run_txn(input logic [ADDR_W-1:0] base, input logic [8:0] len,
                           input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] rv,
                           input int wp, input bit poke_start, input string tag);
        bit seen;
        int werr;
        logic [ADDR_W-1:0] ea;
        logic [DATA_W-1:0] ed;
        clear_mon();
        wprob    = wp;
        rd_val   = rv;
        start    = 1'b1;
        cmd_base = base;
        cmd_len  = len;
        cmd_data = data;
        tick();
        start    = 1'b0;
        cmd_base = ADDR_W'($urandom);
        cmd_len  = 9'($urandom);
        cmd_data = $urandom;
        seen = 1'b0;
        for (int c = 0; c < 4000 && !seen; c++) begin
            tick();
            if (done) seen = 1'b1;
            else if (poke_start) start = 1'($urandom_range(1));
        end
        check({tag, " timeout"}, 64'(seen), 64'd1);
        if (poke_start) start = 1'b1;   // pulse start while in DONE
        tick();
        start = 1'b0;
        repeat (3) tick();

        check({tag, " wcount"}, 64'(wa_q.size()), 64'(len));
        werr = 0;
        for (int k = 0; k < wa_q.size() && k < int'(len); k++) begin
            ea = base + ADDR_W'(k);
            ed = data + DATA_W'(k);
            if (wa_q[k] !== ea || wd_q[k] !== ed) werr++;
        end
        check({tag, " wcontent_errs"}, 64'(werr), 64'd0);
        check({tag, " rcount"}, 64'(ra_q.size()), 64'd1);
        ea = base + ADDR_W'(len);
        check({tag, " raddr"}, (ra_q.size() > 0) ? 64'(ra_q[0]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(ea));
        check({tag, " result"}, 64'(result), 64'(rv));
        check({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
        check({tag, " protocol_errs"}, 64'(inv_err), 64'd0);
        check({tag, " busy_cycles"}, 64'(busy_cycles), 64'(int'(len) + 2 + stall_cycles));
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        logic [8:0]        len;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] rdval;
        logic [ADDR_W-1:0] exp_raddr;
        int                exp_busy;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{17'h00000, 9'd8,   32'h0000_0000, 32'h0000_001C, 17'h00008, 10};
        vecs[1] = '{17'h00010, 9'd0,   32'hDEAD_BEEF, 32'h0000_ABCD, 17'h00010, 2};
        vecs[2] = '{17'h1FFFE, 9'd3,   32'h0000_0100, 32'hCAFE_0001, 17'h00001, 5};
        vecs[3] = '{17'h00005, 9'd2,   32'hFFFF_FFFF, 32'h5A5A_5A5A, 17'h00007, 4};
        vecs[4] = '{17'h1FFFF, 9'd511, 32'hFFFF_FF00, 32'h1234_5678, 17'h001FE, 513};

        reset = 1'b1; start = 1'b0;
        cmd_base = '0; cmd_len = '0; cmd_data = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0;
        wprob = 0; stall_idx = -1; stall_left = 0;
        rd_pending = 1'b0; prev_stall = 1'b0;
        prev_addr = '0; prev_wdata = '0; prev_rd = 1'b0; prev_wr = 1'b0;
        rd_val = '0;
        clear_mon();

        repeat (3) tick();
        check("rst busy",      64'(busy),           64'd0);
        check("rst done",      64'(done),           64'd0);
        check("rst cs",        64'(avm_chipselect), 64'd0);
        check("rst read",      64'(avm_read),       64'd0);
        check("rst write",     64'(avm_write),      64'd0);
        check("rst address",   64'(avm_address),    64'd0);
        check("rst writedata", 64'(avm_writedata),  64'd0);
        check("rst result",    64'(result),         64'd0);
        reset = 1'b0;
        tick();

        // Table vectors, no stalls: exact cycle counts and read address.
        for (int v = 0; v < 5; v++) begin
            run_txn(vecs[v].base, vecs[v].len, vecs[v].data, vecs[v].rdval, 0, 1'b0,
                    $sformatf("vec%0d", v));
            check($sformatf("vec%0d tbl_raddr", v),
                  (ra_q.size() > 0) ? 64'(ra_q[0]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(vecs[v].exp_raddr));
            check($sformatf("vec%0d tbl_busy", v), 64'(busy_cycles), 64'(vecs[v].exp_busy));
            check($sformatf("vec%0d tbl_result", v), 64'(result), 64'(vecs[v].rdval));
        end

        // Two-cycle stall on the second write of three.
        stall_idx = 1; stall_left = 2;
        run_txn(17'h00000, 9'd3, 32'h0000_0050, 32'h7777_0003, 0, 1'b0, "stall");
        check("stall write_cycles", 64'(wr_cycles), 64'd5);
        check("stall stalled",      64'(stall_cycles), 64'd2);
        stall_idx = -1; stall_left = 0;

        // Reset while the fifth write (i=4) is on the bus.
        clear_mon();
        wprob = 0;
        start = 1'b1; cmd_base = 17'h00100; cmd_len = 9'd8; cmd_data = 32'h0000_1000;
        tick();
        start = 1'b0;
        for (int c = 0; c < 50 && wa_q.size() < 4; c++) tick();
        tick();
        check("abort i4 addr", 64'(avm_address), 64'h104);
        reset = 1'b1;
        tick();
        check("abort write",     64'(avm_write),      64'd0);
        check("abort read",      64'(avm_read),       64'd0);
        check("abort cs",        64'(avm_chipselect), 64'd0);
        check("abort busy",      64'(busy),           64'd0);
        check("abort done",      64'(done),           64'd0);
        check("abort address",   64'(avm_address),    64'd0);
        check("abort result",    64'(result),         64'd0);
        begin
            int snap;
            snap = wa_q.size();
            reset = 1'b0;
            done_cnt = 0;
            repeat (10) tick();
            check("abort no_more_writes", 64'(wa_q.size()), 64'(snap));
            check("abort no_done",        64'(done_cnt),    64'd0);
            check("abort no_read",        64'(ra_q.size()), 64'd0);
        end
        run_txn(17'h00200, 9'd4, 32'h0000_2000, 32'h0BAD_F00D, 0, 1'b0, "post_abort");

        // start toggled while busy and held in DONE must be ignored.
        run_txn(17'h00040, 9'd4, 32'h0000_0007, 32'h1357_9BDF, 20, 1'b1, "poke");
        check("poke idle_busy", 64'(busy), 64'd0);

        // Randomized transactions with random waitrequest density.
        for (int t = 0; t < 30; t++) begin
            run_txn(ADDR_W'($urandom), 9'($urandom_range(0, 24)), $urandom, $urandom,
                    int'($urandom_range(0, 60)), 1'($urandom_range(1)), $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
